// File: rtl/int_responder.sv
// int_responder: bench-side interrupt source; raises interrupt when macroscopic_pc hits TRIG_PC, holds it until an ack write to INT_ADDR, re-arms after GAP_CYCLES.
// Latency: interrupt is registered, high the cycle after the matching PC edge. No backpressure: an ack is consumed in whatever cycle it appears.
// Optional trace: define INT_RESP_LOG_EN for $display of fire/ack/timeout events (simulation only).
module int_responder #(
    parameter logic [31:0] INT_ADDR   = 32'h0000_7F20,
    parameter logic [31:0] TRIG_PC    = 32'h0000_3010,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned MAX_FIRES  = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [7:0]  fire_count,
    output logic [7:0]  spurious_count,
    output logic [1:0]  state,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ASSERT = 2'b01,
        S_GAP    = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);
    localparam logic [31:0] FIRE_LIMIT = 32'(MAX_FIRES);
    localparam bit          TO_EN      = (TIMEOUT != 0);
    localparam bit          LIMIT_EN   = (MAX_FIRES != 0);

    state_t      state_q, state_d;
    logic [31:0] pc_prev;
    logic [31:0] gap_cnt;
    logic [31:0] to_cnt;
    logic        ack, match;
    logic        fire, ack_ok, to_hit;

    assign ack   = (|m_int_byteen) && (m_int_addr[31:2] == INT_ADDR[31:2]);
    // Edge-qualified so a PC stalled on the trigger address requests only once.
    assign match = (macroscopic_pc == TRIG_PC) && (pc_prev != TRIG_PC);
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        ack_ok  = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && match) begin
                    state_d = S_ASSERT;
                    fire    = 1'b1;
                end
            end
            S_ASSERT: begin
                // Ack takes priority over a coincident timeout.
                if (ack) begin
                    state_d = S_GAP;
                    ack_ok  = 1'b1;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    state_d = S_DONE;
                    to_hit  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (LIMIT_EN && ({24'd0, fire_count} == FIRE_LIMIT))
                        state_d = S_DONE;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            interrupt      <= 1'b0;
            fire_count     <= 8'd0;
            spurious_count <= 8'd0;
            err_timeout    <= 1'b0;
            pc_prev        <= 32'd0;
            gap_cnt        <= 32'd0;
            to_cnt         <= 32'd0;
        end else begin
            state_q   <= state_d;
            interrupt <= (state_d == S_ASSERT);
            pc_prev   <= macroscopic_pc;

            if (fire) begin
                to_cnt <= 32'd0;
                if (fire_count != 8'hFF)
                    fire_count <= fire_count + 8'd1;
            end else if (state_q == S_ASSERT) begin
                to_cnt <= to_cnt + 32'd1;
            end

            if (ack_ok)
                gap_cnt <= 32'd0;
            else if (state_q == S_GAP)
                gap_cnt <= gap_cnt + 32'd1;

            if (to_hit)
                err_timeout <= 1'b1;

            if (ack && (state_q != S_ASSERT) && (spurious_count != 8'hFF))
                spurious_count <= spurious_count + 8'd1;
        end
    end

`ifdef INT_RESP_LOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if (fire)
                $display("%d@%h: #interrupt fire %0d", $time, macroscopic_pc, int'(fire_count) + 1);
            if (ack_ok)
                $display("%d@%h: #interrupt ack", $time, macroscopic_pc);
            if (to_hit)
                $display("%d@%h: #interrupt timeout, no ack", $time, macroscopic_pc);
        end
    end
`endif

endmodule

// File: tb/tb_int_responder.sv
// Bench for int_responder: table rows of {inputs, expected outputs} pushed into a scoreboard and popped after each edge.
// dut_a uses default parameters; dut_b uses MAX_FIRES=2, TIMEOUT=8 for the limit and timeout sequences.
module tb_int_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] macroscopic_pc;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;

    logic        a_int, b_int;
    logic [7:0]  a_fc, a_sc, b_fc, b_sc;
    logic [1:0]  a_st, b_st;
    logic        a_err, b_err;

    always #5 clk = ~clk;

    int_responder dut_a (
        .clk(clk), .reset(reset), .enable(enable), .macroscopic_pc(macroscopic_pc),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .interrupt(a_int), .fire_count(a_fc), .spurious_count(a_sc),
        .state(a_st), .err_timeout(a_err)
    );

    int_responder #(.MAX_FIRES(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .macroscopic_pc(macroscopic_pc),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .interrupt(b_int), .fire_count(b_fc), .spurious_count(b_sc),
        .state(b_st), .err_timeout(b_err)
    );

    localparam logic [1:0] I = 2'b00, A = 2'b01, G = 2'b10, D = 2'b11;
    localparam logic [1:0] W_A = 2'b01, W_B = 2'b10, W_AB = 2'b11;
    localparam logic [31:0] ACK_ADDR = 32'h0000_7F20;

    typedef struct {
        logic [1:0]  which;
        logic        en;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        intr;
        logic [1:0]  st;
        logic [7:0]  fc;
        logic [7:0]  sc;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic logic [19:0] pack(logic i, logic [1:0] s, logic [7:0] f, logic [7:0] c, logic e);
        return {i, s, f, c, e};
    endfunction

    task automatic check(string name, logic [19:0] act, logic [19:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got int=%b st=%b fc=%0d sc=%0d err=%b, expected int=%b st=%b fc=%0d sc=%0d err=%b",
                     name, act[19], act[18:17], act[16:9], act[8:1], act[0],
                     exp[19], exp[18:17], exp[16:9], exp[8:1], exp[0]);
    endtask

    function automatic void add(logic [1:0] w, logic en, logic [31:0] pc, logic [31:0] addr, logic [3:0] be,
                                logic i, logic [1:0] s, logic [7:0] f, logic [7:0] c, logic e);
        vec_t v;
        v.which = w; v.en = en; v.pc = pc; v.addr = addr; v.be = be;
        v.intr = i; v.st = s; v.fc = f; v.sc = c; v.err = e;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl(string name);
        vec_t e;
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            enable         = tbl[k].en;
            macroscopic_pc = tbl[k].pc;
            m_int_addr     = tbl[k].addr;
            m_int_byteen   = tbl[k].be;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (e.which[0])
                check($sformatf("%s[%0d].a", name, k), pack(a_int, a_st, a_fc, a_sc, a_err),
                      pack(e.intr, e.st, e.fc, e.sc, e.err));
            if (e.which[1])
                check($sformatf("%s[%0d].b", name, k), pack(b_int, b_st, b_fc, b_sc, b_err),
                      pack(e.intr, e.st, e.fc, e.sc, e.err));
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        enable         = 1'b0;
        macroscopic_pc = 32'h3000;
        m_int_addr     = 32'd0;
        m_int_byteen   = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        macroscopic_pc = 32'h3000;
        m_int_addr     = 32'd0;
        m_int_byteen   = 4'd0;

        // Reset state, release, and enable gating of an edge match.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_assert.a", pack(a_int, a_st, a_fc, a_sc, a_err), 20'd0);
        check("rst_assert.b", pack(b_int, b_st, b_fc, b_sc, b_err), 20'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release.a", pack(a_int, a_st, a_fc, a_sc, a_err), 20'd0);
        check("rst_release.b", pack(b_int, b_st, b_fc, b_sc, b_err), 20'd0);
        add(W_AB, 0, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 0, 32'h3010, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h3010, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        run_tbl("t1_idle");

        // Single fire, ack after 3 cycles, 16-cycle gap; enable dropped mid-sequence.
        do_reset();
        add(W_AB, 1, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h3004, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h3008, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h300C, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h3010, 0, 0, 1, A, 1, 0, 0);
        add(W_AB, 0, 32'h3014, 0, 0, 1, A, 1, 0, 0);
        add(W_AB, 0, 32'h3018, 32'h7F24, 4'hF, 1, A, 1, 0, 0);
        add(W_AB, 0, 32'h301C, ACK_ADDR, 4'h1, 0, G, 1, 0, 0);
        for (int k = 1; k <= 15; k++)
            add(W_AB, (k >= 4), (k == 5) ? 32'h3010 : 32'h3020 + 32'(4 * k), 0, 0, 0, G, 1, 0, 0);
        add(W_AB, 1, 32'h3100, 0, 0, 0, I, 1, 0, 0);
        add(W_AB, 1, 32'h3104, 0, 0, 0, I, 1, 0, 0);
        run_tbl("t2_fire");

        // PC stalled on the trigger for 40 cycles fires once.
        do_reset();
        add(W_AB, 1, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        add(W_AB, 1, 32'h3010, 0, 0, 1, A, 1, 0, 0);
        add(W_AB, 1, 32'h3010, ACK_ADDR, 4'h1, 0, G, 1, 0, 0);
        for (int k = 0; k < 15; k++) add(W_AB, 1, 32'h3010, 0, 0, 0, G, 1, 0, 0);
        for (int k = 0; k < 23; k++) add(W_AB, 1, 32'h3010, 0, 0, 0, I, 1, 0, 0);
        add(W_AB, 1, 32'h3000, 0, 0, 0, I, 1, 0, 0);
        run_tbl("t3_stall");

        // MAX_FIRES=2: two acked fires then DONE; third pass ignored, its ack spurious.
        do_reset();
        for (int p = 1; p <= 2; p++) begin
            add(W_B, 1, 32'h3000, 0, 0, 0, I, 8'(p - 1), 0, 0);
            add(W_B, 1, 32'h3010, 0, 0, 1, A, 8'(p), 0, 0);
            add(W_B, 1, 32'h3014, ACK_ADDR, 4'h1, 0, G, 8'(p), 0, 0);
            for (int k = 0; k < 15; k++) add(W_B, 1, 32'h3018, 0, 0, 0, G, 8'(p), 0, 0);
            add(W_B, 1, 32'h3018, 0, 0, 0, (p == 2) ? D : I, 8'(p), 0, 0);
        end
        add(W_B, 1, 32'h3000, 0, 0, 0, D, 2, 0, 0);
        add(W_B, 1, 32'h3010, 0, 0, 0, D, 2, 0, 0);
        add(W_B, 1, 32'h3014, ACK_ADDR, 4'h1, 0, D, 2, 1, 0);
        add(W_B, 1, 32'h3018, 0, 0, 0, D, 2, 1, 0);
        run_tbl("t4_limit");

        // TIMEOUT=8: no ack -> DONE with error; ack coincident with timeout wins.
        do_reset();
        add(W_B, 1, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        add(W_B, 1, 32'h3010, 0, 0, 1, A, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(W_B, 1, 32'h3014, 0, 0, 1, A, 1, 0, 0);
        add(W_B, 1, 32'h3018, 0, 0, 0, D, 1, 0, 1);
        add(W_B, 1, 32'h3018, 0, 0, 0, D, 1, 0, 1);
        run_tbl("t5_timeout");
        do_reset();
        add(W_B, 1, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        add(W_B, 1, 32'h3010, 0, 0, 1, A, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(W_B, 1, 32'h3014, 0, 0, 1, A, 1, 0, 0);
        add(W_B, 1, 32'h3018, ACK_ADDR, 4'h1, 0, G, 1, 0, 0);
        add(W_B, 1, 32'h301C, 0, 0, 0, G, 1, 0, 0);
        run_tbl("t5_ack_wins");

        // Spurious acks (low address bits ignored), match+ack in IDLE, async reset mid-ASSERT.
        do_reset();
        add(W_A, 1, 32'h3000, 32'h7F23, 4'h8, 0, I, 0, 1, 0);
        add(W_A, 1, 32'h3004, 0, 0, 0, I, 0, 1, 0);
        add(W_A, 1, 32'h3010, ACK_ADDR, 4'h4, 1, A, 1, 2, 0);
        add(W_A, 1, 32'h3014, 0, 0, 1, A, 1, 2, 0);
        run_tbl("t6_spurious");
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_rst.a", pack(a_int, a_st, a_fc, a_sc, a_err), 20'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        add(W_A, 1, 32'h3000, 0, 0, 0, I, 0, 0, 0);
        run_tbl("t6_after");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
